// File: rtl/branch_predict_ctrl_pkg.sv
// Shared types and helpers for the branch predictor: FSM states,
// 2-bit counter encodings and the saturating counter step.
package branch_pred_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  localparam int FLUSH_CNT_W = 4;

  function automatic logic [1:0] sat_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (cur == CNT_ST) ? CNT_ST : cur + 2'd1;
    end else begin
      nxt = (cur == CNT_SNT) ? CNT_SNT : cur - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_if.sv
// Pipeline <-> predictor bundle: fetch lookup, EX resolution, recovery and stats.
interface branch_predict_ctrl_if;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic        ex_mispredict;
  logic [31:0] ex_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        busy;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  // Pipeline side
  modport master (
    output if_valid, if_pc, ex_branch, ex_pc, ex_taken, ex_mispredict, ex_target,
    input  pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex, busy,
           stat_branches, stat_mispredicts
  );

  // Predictor side
  modport slave (
    input  if_valid, if_pc, ex_branch, ex_pc, ex_taken, ex_mispredict, ex_target,
    output pred_taken, redirect_valid, redirect_pc, flush_if_id, flush_id_ex, busy,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_ctrl_bht_counter_table.sv
// Untagged table of 2-bit saturating counters: combinational read,
// synchronous saturating update, every entry reset to CNT_INIT.
module bht_counter_table
  import branch_pred_pkg::*;
#(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CNT_INIT   = CNT_WNT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [1:0]            rd_cnt,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [2*DEPTH-1:0] cnt_flat;

  // Each entry is its own register so the whole table can reset at once.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [1:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= CNT_INIT;
        end else if (wr_en && (wr_idx == INDEX_BITS'(gi))) begin
          cnt_reg <= sat_next(cnt_reg, wr_taken);
        end
      end

      assign cnt_flat[2*gi +: 2] = cnt_reg;
    end
  endgenerate

  // Read returns the pre-update value when the same index is written this cycle.
  assign rd_cnt = cnt_flat[{rd_idx, 1'b0} +: 2];

endmodule

// File: rtl/branch_predict_ctrl.sv
// Branch predictor front end: counter-table lookup, training from EX,
// mispredict recovery FSM (redirect pulse + timed flush) and statistics.
module branch_predict_ctrl
  import branch_pred_pkg::*;
#(
  parameter int         INDEX_BITS   = 6,
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [1:0] CNT_INIT     = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  branch_predict_ctrl_if.slave bus
);

  state_t                 state_reg;
  logic [FLUSH_CNT_W-1:0] flush_cnt_reg;
  logic                   redirect_valid_reg;
  logic [31:0]            redirect_pc_reg;
  logic                   flush_reg;
  logic [31:0]            stat_branches_reg;
  logic [31:0]            stat_mispredicts_reg;

  logic [INDEX_BITS-1:0]  rd_idx;
  logic [INDEX_BITS-1:0]  wr_idx;
  logic [1:0]             rd_cnt;
  logic                   accept;
  logic                   unused_pc_bits;

  assign rd_idx = bus.if_pc[INDEX_BITS+1:2];
  assign wr_idx = bus.ex_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{bus.if_pc[31:INDEX_BITS+2], bus.if_pc[1:0]};

  // Resolutions seen during FLUSH belong to squashed wrong-path instructions.
  assign accept = bus.ex_branch && (state_reg == IDLE);

  bht_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .CNT_INIT   (CNT_INIT)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (rd_idx),
    .rd_cnt   (rd_cnt),
    .wr_en    (accept),
    .wr_idx   (wr_idx),
    .wr_taken (bus.ex_taken)
  );

  assign bus.pred_taken = bus.if_valid & rd_cnt[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      flush_cnt_reg      <= '0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= '0;
      flush_reg          <= 1'b0;
    end else begin
      redirect_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept && bus.ex_mispredict) begin
            state_reg          <= FLUSH;
            redirect_valid_reg <= 1'b1;
            flush_reg          <= 1'b1;
            redirect_pc_reg    <= bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
            flush_cnt_reg      <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          // Counter reaching zero marks the last flush cycle.
          if (flush_cnt_reg == '0) begin
            state_reg <= IDLE;
            flush_reg <= 1'b0;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          flush_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else if (accept) begin
      stat_branches_reg <= stat_branches_reg + 32'd1;
      if (bus.ex_mispredict) begin
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
      end
    end
  end

  assign bus.redirect_valid   = redirect_valid_reg;
  assign bus.redirect_pc      = redirect_pc_reg;
  assign bus.flush_if_id      = flush_reg;
  assign bus.flush_id_ex      = flush_reg;
  assign bus.busy             = flush_reg;
  assign bus.stat_branches    = stat_branches_reg;
  assign bus.stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Scoreboard bench: dut_a (FLUSH_CYCLES=2) and dut_b (FLUSH_CYCLES=3) share fetch/EX
// data but have independent ex_branch strobes; redirects are checked by a monitor.
module tb_branch_predict_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_predict_ctrl_if ifa ();
  branch_predict_ctrl_if ifb ();

  branch_predict_ctrl #(.INDEX_BITS(6), .FLUSH_CYCLES(2), .CNT_INIT(2'b01)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  branch_predict_ctrl #(.INDEX_BITS(6), .FLUSH_CYCLES(3), .CNT_INIT(2'b01)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] pc;
    int          len;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  bit mon_act  [2];
  int mon_len  [2];
  int mon_exp  [2];
  bit mon_flok [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Pops an expected redirect on each pulse, then measures the busy window.
  task automatic mon_step(input int d, input logic rv, input logic [31:0] rpc,
                          input logic bsy, input logic f1, input logic f2);
    exp_t e;
    if (rv) begin
      tests++;
      if ((d == 0) ? (qa.size() == 0) : (qb.size() == 0)) begin
        fails++;
        $display("FAIL redirect_unexpected dut%0d: got redirect_pc=%h, required no redirect", d, rpc);
      end else begin
        if (d == 0) e = qa.pop_front();
        else        e = qb.pop_front();
        if (rpc !== e.pc) begin
          fails++;
          $display("FAIL redirect_pc dut%0d: got %h, required %h", d, rpc, e.pc);
        end else begin
          $display("[TB] dut%0d redirect to %h", d, rpc);
        end
        mon_act[d]  = 1'b1;
        mon_len[d]  = 0;
        mon_exp[d]  = e.len;
        mon_flok[d] = 1'b1;
      end
    end
    if (mon_act[d]) begin
      if (bsy === 1'b1) begin
        mon_len[d]++;
        if (f1 !== 1'b1 || f2 !== 1'b1) mon_flok[d] = 1'b0;
      end else begin
        tests++;
        if (mon_len[d] != mon_exp[d] || !mon_flok[d]) begin
          fails++;
          $display("FAIL flush_window dut%0d: got %0d busy cycles (flush ok=%0d), required %0d with flush ok=1",
                   d, mon_len[d], mon_flok[d], mon_exp[d]);
        end
        mon_act[d] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      mon_act[0] = 1'b0;
      mon_act[1] = 1'b0;
    end else begin
      mon_step(0, ifa.redirect_valid, ifa.redirect_pc, ifa.busy, ifa.flush_if_id, ifa.flush_id_ex);
      mon_step(1, ifb.redirect_valid, ifb.redirect_pc, ifb.busy, ifb.flush_if_id, ifb.flush_id_ex);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] pc, input logic tk, input logic mis, input logic [31:0] tgt);
    ifa.ex_pc = pc;  ifa.ex_taken = tk;  ifa.ex_mispredict = mis;  ifa.ex_target = tgt;
    ifb.ex_pc = pc;  ifb.ex_taken = tk;  ifb.ex_mispredict = mis;  ifb.ex_target = tgt;
  endtask

  task automatic resolve(input logic [1:0] m, input logic [31:0] pc, input logic tk,
                         input logic mis, input logic [31:0] tgt);
    set_ex(pc, tk, mis, tgt);
    ifa.ex_branch = m[0];
    ifb.ex_branch = m[1];
    $display("[TB] resolve mask=%b pc=%h taken=%b mispredict=%b target=%h", m, pc, tk, mis, tgt);
    tick(1);
    ifa.ex_branch = 1'b0;
    ifb.ex_branch = 1'b0;
  endtask

  task automatic check_pred(input logic [1:0] m, input logic [31:0] pc, input logic v, input logic exp);
    ifa.if_pc = pc;  ifa.if_valid = v;
    ifb.if_pc = pc;  ifb.if_valid = v;
    @(negedge clk);
    if (m[0]) chk($sformatf("pred_a pc=%h valid=%b", pc, v), 32'(ifa.pred_taken), 32'(exp));
    if (m[1]) chk($sformatf("pred_b pc=%h valid=%b", pc, v), 32'(ifb.pred_taken), 32'(exp));
    tick(1);
  endtask

  logic exp_nt [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.if_valid = 1'b0;  ifa.if_pc = '0;  ifa.ex_branch = 1'b0;
    ifb.if_valid = 1'b0;  ifb.if_pc = '0;  ifb.ex_branch = 1'b0;
    set_ex(32'h0, 1'b0, 1'b0, 32'h0);

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_redirect_valid", 32'(ifa.redirect_valid), 32'd0);
    chk("rst_busy",           32'(ifa.busy), 32'd0);
    chk("rst_flush_if_id",    32'(ifa.flush_if_id), 32'd0);
    chk("rst_flush_id_ex",    32'(ifa.flush_id_ex), 32'd0);
    chk("rst_redirect_pc",    ifa.redirect_pc, 32'h0);
    chk("rst_stat_branches",  ifa.stat_branches, 32'd0);
    chk("rst_stat_mispred",   ifa.stat_mispredicts, 32'd0);
    chk("rst_b_busy",         32'(ifb.busy), 32'd0);
    tick(1);

    // Every entry starts weakly not-taken
    for (int a = 0; a < 64; a++) check_pred(2'b11, 32'(a * 4), 1'b1, 1'b0);
    check_pred(2'b11, 32'h40, 1'b0, 1'b0);

    // Training and saturation at 0x40
    for (int i = 0; i < 3; i++) begin
      resolve(2'b01, 32'h40, 1'b1, 1'b0, 32'h0);
      check_pred(2'b01, 32'h40, 1'b1, 1'b1);
    end
    check_pred(2'b01, 32'h40, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      resolve(2'b01, 32'h40, 1'b0, 1'b0, 32'h0);
      check_pred(2'b01, 32'h40, 1'b1, exp_nt[i]);
    end
    chk("train_stat_branches", ifa.stat_branches, 32'd7);
    chk("train_stat_mispred",  ifa.stat_mispredicts, 32'd0);

    // Taken mispredict
    qa.push_back(exp_t'{32'h100, 2});
    resolve(2'b01, 32'h40, 1'b1, 1'b1, 32'h100);
    tick(3);
    chk("tm_stat_branches", ifa.stat_branches, 32'd8);
    chk("tm_stat_mispred",  ifa.stat_mispredicts, 32'd1);
    chk("tm_busy_after",    32'(ifa.busy), 32'd0);
    chk("tm_redirect_hold", ifa.redirect_pc, 32'h100);
    chk("tm_b_untouched",   ifb.stat_branches, 32'd0);

    // Not-taken mispredict, fall-through wraps
    qa.push_back(exp_t'{32'h0, 2});
    resolve(2'b01, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
    tick(3);
    chk("wrap_stat_branches", ifa.stat_branches, 32'd9);
    chk("wrap_stat_mispred",  ifa.stat_mispredicts, 32'd2);

    // Back-to-back correct predictions
    resolve(2'b01, 32'h8, 1'b1, 1'b0, 32'h0);
    resolve(2'b01, 32'h8, 1'b1, 1'b0, 32'h0);
    chk("b2b_stat_branches", ifa.stat_branches, 32'd11);
    check_pred(2'b01, 32'h8, 1'b1, 1'b1);

    // Wrong-path resolutions during FLUSH on dut_a, then accept on first IDLE cycle
    resolve(2'b01, 32'h80, 1'b1, 1'b0, 32'h0);
    check_pred(2'b01, 32'h80, 1'b1, 1'b1);
    qa.push_back(exp_t'{32'h200, 2});
    resolve(2'b01, 32'h40, 1'b1, 1'b1, 32'h200);
    set_ex(32'h80, 1'b0, 1'b1, 32'h0);
    ifa.ex_branch = 1'b1;
    tick(2);
    set_ex(32'h8, 1'b0, 1'b0, 32'h0);
    tick(1);
    ifa.ex_branch = 1'b0;
    check_pred(2'b01, 32'h80, 1'b1, 1'b1);
    check_pred(2'b01, 32'h8, 1'b1, 1'b1);
    check_pred(2'b01, 32'h40, 1'b1, 1'b1);
    chk("wp_a_stat_branches", ifa.stat_branches, 32'd14);
    chk("wp_a_stat_mispred",  ifa.stat_mispredicts, 32'd3);

    // Wrong-path with FLUSH_CYCLES=3 on dut_b
    resolve(2'b10, 32'h80, 1'b1, 1'b0, 32'h0);
    check_pred(2'b10, 32'h80, 1'b1, 1'b1);
    qb.push_back(exp_t'{32'h300, 3});
    resolve(2'b10, 32'h40, 1'b1, 1'b1, 32'h300);
    set_ex(32'h80, 1'b0, 1'b1, 32'h0);
    ifb.ex_branch = 1'b1;
    tick(2);
    ifb.ex_branch = 1'b0;
    chk("wp_b_busy_cycle3", 32'(ifb.busy), 32'd1);
    tick(1);
    chk("wp_b_busy_after",  32'(ifb.busy), 32'd0);
    check_pred(2'b10, 32'h80, 1'b1, 1'b1);
    chk("wp_b_stat_branches", ifb.stat_branches, 32'd2);
    chk("wp_b_stat_mispred",  ifb.stat_mispredicts, 32'd1);
    chk("wp_b_a_unchanged",   ifa.stat_branches, 32'd14);

    // Reset during first FLUSH cycle
    resolve(2'b01, 32'h40, 1'b1, 1'b1, 32'h400);
    chk("mid_rv_before_rst", 32'(ifa.redirect_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_redirect_valid", 32'(ifa.redirect_valid), 32'd0);
    chk("mid_rst_busy",           32'(ifa.busy), 32'd0);
    chk("mid_rst_flush_if_id",    32'(ifa.flush_if_id), 32'd0);
    chk("mid_rst_flush_id_ex",    32'(ifa.flush_id_ex), 32'd0);
    chk("mid_rst_redirect_pc",    ifa.redirect_pc, 32'h0);
    chk("mid_rst_stat_branches",  ifa.stat_branches, 32'd0);
    chk("mid_rst_stat_mispred",   ifa.stat_mispredicts, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("post_rst_busy", 32'(ifa.busy), 32'd0);
    check_pred(2'b01, 32'h40, 1'b1, 1'b0);

    // Aliasing: 0x000 and 0x100 share index 0
    resolve(2'b01, 32'h0, 1'b1, 1'b0, 32'h0);
    resolve(2'b01, 32'h0, 1'b1, 1'b0, 32'h0);
    check_pred(2'b01, 32'h100, 1'b1, 1'b1);
    chk("alias_stat_branches", ifa.stat_branches, 32'd2);

    tick(4);
    chk("pending_redirects_a", 32'(qa.size()), 32'd0);
    chk("pending_redirects_b", 32'(qb.size()), 32'd0);
    chk("open_flush_a", 32'(mon_act[0]), 32'd0);
    chk("open_flush_b", 32'(mon_act[1]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
